// File: rtl/ser_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial bit feeder.
package ser_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } ser_state_t;

    localparam int unsigned MIN_WIDTH     = 2;
    localparam int unsigned MAX_WIDTH     = 32;
    localparam int unsigned DEFAULT_WIDTH = 4;

    // Bit-counter width for a given word width (never narrower than one bit).
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/ser_bit_feeder_if.sv
// Word-in / bit-out bundle between an upstream word source and the bit feeder.
interface ser_bit_feeder_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_out, ser_valid, word_done, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_out, ser_valid, word_done, busy
    );
endinterface

// File: rtl/ser_hold_reg.sv
// Single-entry word buffer; ready whenever the entry is empty.
module ser_hold_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load,
    input  logic             take,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             ready
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (take) begin
            valid <= 1'b0;
        end
    end

    assign ready = !valid;

endmodule

// File: rtl/ser_bit_feeder.sv
// Parallel-to-serial feeder: WIDTH-bit words in over valid/ready, one bit per clk out,
// with a one-word hold buffer so consecutive words stream without a gap.
module ser_bit_feeder
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b0,
    parameter logic        IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    ser_bit_feeder_if.slave  bus
);

    localparam int unsigned         CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]    LAST  = CNT_W'(WIDTH - 1);

    ser_state_t       state;
    logic [WIDTH-1:0] sh;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hold_data;
    logic             hold_valid;
    logic             hold_ready;

    logic             ser_out_q;
    logic             ser_valid_q;
    logic             word_done_q;

    logic             accept;
    logic             last;
    logic             load_sh;
    logic             hold_load;
    logic             hold_take;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] sh_shift;
    logic [CNT_W-1:0] cnt_inc;

    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load_data (bus.in_data),
        .load      (hold_load),
        .take      (hold_take),
        .data      (hold_data),
        .valid     (hold_valid),
        .ready     (hold_ready)
    );

    // At the last bit a held word has priority; otherwise a fresh word may bypass the hold.
    always_comb begin
        accept    = bus.in_valid && hold_ready;
        last      = (state == S_SHIFT) && (cnt == LAST);
        hold_take = last && hold_valid;
        hold_load = accept && (state == S_SHIFT) && !last;
        load_sh   = hold_take || (accept && ((state == S_IDLE) || (last && !hold_valid)));
        load_word = hold_take ? hold_data : bus.in_data;
        sh_shift  = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
        cnt_inc   = cnt + CNT_W'(1);
    end

    // FSM, shifter and counter; serial outputs are registered from next-cycle values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            sh          <= '0;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
        end else if (load_sh) begin
            state       <= S_SHIFT;
            cnt         <= '0;
            sh          <= load_word;
            ser_out_q   <= out_bit(load_word);
            ser_valid_q <= 1'b1;
            word_done_q <= 1'b0;
        end else if ((state == S_SHIFT) && !last) begin
            cnt         <= cnt_inc;
            sh          <= sh_shift;
            ser_out_q   <= out_bit(sh_shift);
            ser_valid_q <= 1'b1;
            word_done_q <= (cnt_inc == LAST);
        end else if (last) begin
            state       <= S_IDLE;
            cnt         <= '0;
            sh          <= sh_shift;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
        end
    end

    assign bus.in_ready  = hold_ready;
    assign bus.busy      = (state == S_SHIFT) || hold_valid;
    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.word_done = word_done_q;

endmodule

// File: doc/ser_bit_feeder.md
Name: ser_bit_feeder

Overview:
- Parallel-to-serial front end that feeds single-bit sequence detectors (e.g. the 1001 detector), which sample one bit per clk.
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per cycle.
- Holds a one-word buffer so back-to-back words stream with no idle bit between them.
- Drives IDLE_BIT whenever no word is being shifted.

Parameters:
- WIDTH, 4, bits per word; legal range 2..32.
- MSB_FIRST, 0, 0 = bit 0 sent first, 1 = bit WIDTH-1 sent first.
- IDLE_BIT, 1'b0, level driven on ser_out while ser_valid=0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  WIDTH  word to serialize.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word; equals !hold_valid.
- ser_out  out  1  serial bit to the detector (registered).
- ser_valid  out  1  ser_out carries a word bit this cycle (registered).
- word_done  out  1  high during the last bit of each word (registered).
- busy  out  1  shifter active or hold buffer occupied.

Behaviour:
- Accept: a word is accepted at a rising edge when in_valid && in_ready.
- in_ready: combinational from hold_valid only; never depends on in_valid.
- Internal state:
  - shift register sh[WIDTH-1:0];
  - bit counter cnt, width $clog2(WIDTH);
  - hold register hold_data plus hold_valid;
  - 2-state FSM: IDLE and SHIFT.
- IDLE:
  - Outputs: ser_valid=0, ser_out=IDLE_BIT, word_done=0.
  - On accept: load the word into sh, set cnt=0, go to SHIFT. The first bit is on ser_out in the cycle right after the accept edge (latency 1).
- SHIFT:
  - Each cycle drives sh[0] (MSB_FIRST=0) or sh[WIDTH-1] (MSB_FIRST=1), with ser_valid=1.
  - At each edge: shift sh by one position toward the output end, cnt+1.
  - word_done=1 exactly when cnt==WIDTH-1.
- Accept while in SHIFT:
  - If cnt<WIDTH-1 or hold_valid=1, the accepted word goes to the hold register.
  - If cnt==WIDTH-1 and hold empty, the accepted word bypasses hold and loads directly into sh at that edge; cnt=0, state stays SHIFT.
- End of word (edge where cnt==WIDTH-1):
  - hold_valid=1: load hold_data into sh, clear hold_valid, cnt=0, stay in SHIFT (no bubble). in_ready rises the following cycle.
  - hold empty, no accept: go to IDLE. The next cycle shows ser_valid=0 and ser_out=IDLE_BIT.
- Hold full: in_ready=0; in_data/in_valid are ignored. The upstream must hold its word until accepted.
- busy = (state==SHIFT) || hold_valid.
- Reset (rst high at an edge, including mid-word):
  - state=IDLE, cnt=0, hold_valid=0, sh=0.
  - ser_out=IDLE_BIT, ser_valid=0, word_done=0, busy=0.
  - in_ready=1 from the cycle after the reset edge.
  - The partial word and any held word are discarded.
  - An in_valid during a reset cycle is not accepted.
- Throughput: sustained one bit per cycle whenever the upstream keeps in_valid high.
- The detector consumes ser_out unconditionally. IDLE_BIT is therefore part of its input stream; the system integrator chooses IDLE_BIT so idle fill does not form false patterns.

Decomposition:
- Shared package ser_pkg holds:
  - state encoding typedef ser_state_t {S_IDLE, S_SHIFT};
  - localparam for the counter width.
- One natural sub-module, ser_hold_reg: single-entry buffer with data, valid, load and take controls, and ready = !valid.
- FSM, shifter and counter stay in ser_bit_feeder.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> no accept; ser_valid=0, ser_out=0, busy=0, in_ready=1 after the reset edge.
- Single word: WIDTH=4, MSB_FIRST=0, accept 4'b1001 at edge k -> ser_out 1,0,0,1 in cycles k+1..k+4; word_done only in k+4; ser_valid=0 in k+5. With a downstream 1001 detector attached, its out=1 in cycle k+4.
- Back-to-back: in_valid held high with words 4'b1001 then 4'b0110 -> 8 contiguous bits 1,0,0,1,0,1,1,0; ser_valid continuously 1; word_done in bit cycles 4 and 8.
- Backpressure: present 3 words in consecutive cycles -> word 2 goes to hold, in_ready=0 until the edge where word 2 moves into the shifter; word 3 accepted the next cycle; no word lost or duplicated.
- Reset mid-word: rst asserted after 2 bits of 4'b1001 -> next cycle ser_valid=0 and hold cleared; a new word 4'b1111 afterwards shifts out cleanly as 1,1,1,1.
- MSB_FIRST=1, WIDTH=8: word 8'hA5 -> bits 1,0,1,0,0,1,0,1; word_done on the 8th bit.
